// File: rtl/pipe_stage_buf.sv
// Elastic inter-stage pipeline register: a main entry plus a one-deep skid entry
// so InReady is registered, with synchronous flush and a saturating stall counter.
module pipe_stage_buf #(
  parameter int unsigned       WIDTH  = 32,
  parameter logic [WIDTH-1:0]  BUBBLE = {WIDTH{1'b0}},
  parameter int unsigned       CNT_W  = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InData,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] OutData,
  output logic [1:0]       Occupancy,
  output logic [CNT_W-1:0] StallCnt
);

  // State bits are {skid_valid, main_valid}; 2'b10 cannot be reached.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};

  state_t             state_r;
  state_t             state_nxt_s;
  logic [WIDTH-1:0]   main_data_r;
  logic [WIDTH-1:0]   main_data_nxt_s;
  logic [WIDTH-1:0]   skid_data_r;
  logic [WIDTH-1:0]   skid_data_nxt_s;
  logic               in_ready_r;
  logic               in_ready_nxt_s;
  logic [1:0]         occupancy_r;
  logic [1:0]         occupancy_nxt_s;
  logic [CNT_W-1:0]   stall_cnt_r;
  logic               main_valid_s;
  logic               push_s;
  logic               pop_s;

  assign main_valid_s = state_r[0];
  assign push_s       = InValid && in_ready_r;
  assign pop_s        = main_valid_s && OutReady;

  // Next-state and next-data selection for the handshake and flush.
  always_comb begin
    state_nxt_s     = state_r;
    main_data_nxt_s = main_data_r;
    skid_data_nxt_s = skid_data_r;
    if (Flush) begin
      state_nxt_s     = EMPTY;
      main_data_nxt_s = BUBBLE;
      skid_data_nxt_s = BUBBLE;
    end else begin
      case (state_r)
        EMPTY: begin
          if (push_s) begin
            main_data_nxt_s = InData;
            state_nxt_s     = ONE;
          end else begin
            state_nxt_s     = EMPTY;
          end
        end
        ONE: begin
          if (push_s && pop_s) begin
            main_data_nxt_s = InData;
          end else if (push_s) begin
            skid_data_nxt_s = InData;
            state_nxt_s     = FULL;
          end else if (pop_s) begin
            main_data_nxt_s = BUBBLE;
            state_nxt_s     = EMPTY;
          end else begin
            state_nxt_s     = ONE;
          end
        end
        FULL: begin
          // InReady is low here, so only a pop can move the state.
          if (pop_s) begin
            main_data_nxt_s = skid_data_r;
            skid_data_nxt_s = BUBBLE;
            state_nxt_s     = ONE;
          end else begin
            state_nxt_s     = FULL;
          end
        end
        default: begin
          state_nxt_s     = EMPTY;
          main_data_nxt_s = BUBBLE;
          skid_data_nxt_s = BUBBLE;
        end
      endcase
    end
  end

  // Derive the registered InReady and Occupancy from the next state.
  always_comb begin
    in_ready_nxt_s  = 1'b1;
    occupancy_nxt_s = 2'd0;
    case (state_nxt_s)
      EMPTY: begin
        in_ready_nxt_s  = 1'b1;
        occupancy_nxt_s = 2'd0;
      end
      ONE: begin
        in_ready_nxt_s  = 1'b1;
        occupancy_nxt_s = 2'd1;
      end
      FULL: begin
        in_ready_nxt_s  = 1'b0;
        occupancy_nxt_s = 2'd2;
      end
      default: begin
        in_ready_nxt_s  = 1'b1;
        occupancy_nxt_s = 2'd0;
      end
    endcase
  end

  // Storage and status registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r     <= EMPTY;
      main_data_r <= BUBBLE;
      skid_data_r <= BUBBLE;
      in_ready_r  <= 1'b1;
      occupancy_r <= 2'd0;
    end else begin
      state_r     <= state_nxt_s;
      main_data_r <= main_data_nxt_s;
      skid_data_r <= skid_data_nxt_s;
      in_ready_r  <= in_ready_nxt_s;
      occupancy_r <= occupancy_nxt_s;
    end
  end

  // Saturating stall counter; Flush deliberately leaves it alone.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (main_valid_s && !OutReady && (stall_cnt_r != STALL_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign InReady   = in_ready_r;
  assign OutValid  = main_valid_s;
  assign OutData   = main_data_r;
  assign Occupancy = occupancy_r;
  assign StallCnt  = stall_cnt_r;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: default instance plus an all-ones BUBBLE
// instance and a 4-bit counter instance, all sharing one stimulus stream.
module tb_pipe_stage_buf;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Flush = 1'b0;
  logic        InValid = 1'b0;
  logic        OutReady = 1'b0;
  logic [31:0] InData = 32'h0;

  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [1:0]  occ;
  logic [15:0] stall;

  logic        b_in_ready, b_out_valid;
  logic [31:0] b_out_data;
  logic [1:0]  b_occ;
  logic [15:0] b_stall;

  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_data;
  logic [1:0]  s_occ;
  logic [3:0]  s_stall;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  pipe_stage_buf dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush),
    .InValid(InValid), .InReady(in_ready), .InData(InData),
    .OutValid(out_valid), .OutReady(OutReady), .OutData(out_data),
    .Occupancy(occ), .StallCnt(stall)
  );

  pipe_stage_buf #(.WIDTH(32), .BUBBLE(32'hFFFF_FFFF), .CNT_W(16)) dut_b (
    .Clk(Clk), .Reset(Reset), .Flush(Flush),
    .InValid(InValid), .InReady(b_in_ready), .InData(InData),
    .OutValid(b_out_valid), .OutReady(OutReady), .OutData(b_out_data),
    .Occupancy(b_occ), .StallCnt(b_stall)
  );

  pipe_stage_buf #(.WIDTH(32), .BUBBLE(32'h0), .CNT_W(4)) dut_s (
    .Clk(Clk), .Reset(Reset), .Flush(Flush),
    .InValid(InValid), .InReady(s_in_ready), .InData(InData),
    .OutValid(s_out_valid), .OutReady(OutReady), .OutData(s_out_data),
    .Occupancy(s_occ), .StallCnt(s_stall)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; InValid = 1'b1; InData = 32'hDEAD_BEEF; OutReady = 1'b0;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h want=0", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_inready got=%b want=1", in_ready); end
    checks++; if (stall !== 16'd0) begin errors++; $display("FAIL reset_stall got=%0d want=0", stall); end
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL reset_occ got=%0d want=0", occ); end
    checks++; if (b_out_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_bubble_ones got=%h want=ffffffff", b_out_data); end
    Reset = 1'b0; InValid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_nothing_taken got=%b want=0", out_valid); end
  endtask

  task automatic test_streaming();
    OutReady = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      InValid = 1'b1; InData = 32'(i);
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 32'(i)) begin errors++; $display("FAIL stream_data[%0d] got=%b/%h want=1/%h", i, out_valid, out_data, i); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_inready[%0d] got=%b want=1", i, in_ready); end
    end
    InValid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin errors++; $display("FAIL stream_drain got=%b/%h want=0/0", out_valid, out_data); end
    checks++; if (stall !== 16'd0) begin errors++; $display("FAIL stream_stall got=%0d want=0", stall); end
  endtask

  task automatic test_backpressure();
    OutReady = 1'b0; InValid = 1'b1; InData = 32'h11;
    tick();
    checks++; if (out_data !== 32'h11 || occ !== 2'd1) begin errors++; $display("FAIL bp_first got=%h/%0d want=11/1", out_data, occ); end
    InData = 32'h22;
    tick();
    checks++; if (occ !== 2'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got=%0d/%b want=2/0", occ, in_ready); end
    checks++; if (stall !== 16'd1) begin errors++; $display("FAIL bp_stall1 got=%0d want=1", stall); end
    InData = 32'h33;
    tick();
    checks++; if (out_data !== 32'h11 || occ !== 2'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold got=%h/%0d/%b want=11/2/0", out_data, occ, in_ready); end
    checks++; if (stall !== 16'd2) begin errors++; $display("FAIL bp_stall2 got=%0d want=2", stall); end
    OutReady = 1'b1;
    tick();
    checks++; if (out_data !== 32'h22 || occ !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_second got=%h/%0d/%b want=22/1/1", out_data, occ, in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h33) begin errors++; $display("FAIL bp_third got=%b/%h want=1/33", out_valid, out_data); end
    InValid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin errors++; $display("FAIL bp_empty got=%b/%h want=0/0", out_valid, out_data); end
    checks++; if (stall !== 16'd2) begin errors++; $display("FAIL bp_stall_final got=%0d want=2", stall); end
  endtask

  task automatic test_flush();
    OutReady = 1'b0; InValid = 1'b1; InData = 32'h44;
    tick();
    InData = 32'h66;
    tick();
    checks++; if (occ !== 2'd2) begin errors++; $display("FAIL flush_prefill got=%0d want=2", occ); end
    Flush = 1'b1; InData = 32'h77;
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin errors++; $display("FAIL flush_out got=%b/%h want=0/0", out_valid, out_data); end
    checks++; if (occ !== 2'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_state got=%0d/%b want=0/1", occ, in_ready); end
    Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin errors++; $display("FAIL flush_gone got=%b/%h want=0/0", out_valid, out_data); end
  endtask

  task automatic test_drain();
    OutReady = 1'b1; InValid = 1'b1; InData = 32'h55;
    tick();
    checks++; if (out_data !== 32'h55 || b_out_data !== 32'h55) begin errors++; $display("FAIL drain_load got=%h/%h want=55/55", out_data, b_out_data); end
    InValid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin errors++; $display("FAIL drain_zero got=%b/%h want=0/0", out_valid, out_data); end
    checks++; if (b_out_valid !== 1'b0 || b_out_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL drain_ones got=%b/%h want=0/ffffffff", b_out_valid, b_out_data); end
  endtask

  task automatic test_saturation();
    Reset = 1'b1;
    tick();
    Reset = 1'b0; OutReady = 1'b0; InValid = 1'b1; InData = 32'h99;
    tick();
    InValid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    checks++; if (s_stall !== 4'd15) begin errors++; $display("FAIL sat_reach got=%0d want=15", s_stall); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (s_stall !== 4'd15) begin errors++; $display("FAIL sat_hold got=%0d want=15", s_stall); end
    checks++; if (stall !== 16'd20) begin errors++; $display("FAIL sat_wide got=%0d want=20", stall); end
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    checks++; if (s_stall !== 4'd15 || s_out_valid !== 1'b0) begin errors++; $display("FAIL sat_flush got=%0d/%b want=15/0", s_stall, s_out_valid); end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++; if (s_stall !== 4'd0 || stall !== 16'd0) begin errors++; $display("FAIL sat_reset got=%0d/%0d want=0/0", s_stall, stall); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_drain();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised, elastic successor to the fixed inter-stage pipeline registers. It carries one packed payload word between two pipeline stages using a valid/ready handshake. A two-entry skid buffer keeps the upstream ready a registered signal, and it loses no data while the downstream is stalled. It also supports synchronous flush to a bubble value and a saturating stall-cycle counter, so every stage boundary (F/D, D/E, E/M, M/W) uses the same block.

## Interface
- WIDTH, 32: payload width in bits (for example, packed Instr/ALUOut/RD2/A3/WD/PC).
- BUBBLE, {WIDTH{1'b0}}: payload value loaded on reset, flush and drain (all-zero is the NOP encoding).
- CNT_W, 16: width of the stall-cycle counter.
- Clk  input  1  the only clock; everything updates on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- Flush  input  1  synchronous, discards both entries; lower priority than Reset.
- InValid  input  1  upstream presents a payload.
- InReady  output  1  the block can accept; registered, equals !skid_valid.
- InData  input  WIDTH  upstream payload.
- OutValid  output  1  the main entry holds a valid payload.
- OutReady  input  1  downstream consumes this cycle.
- OutData  output  WIDTH  main entry payload; equals BUBBLE whenever OutValid=0.
- Occupancy  output  2  number of valid entries (0, 1 or 2).
- StallCnt  output  CNT_W  count of cycles with OutValid && !OutReady.

## Operation
- Storage:
  - Main entry: main_valid, main_data. Drives OutValid and OutData.
  - Skid entry: skid_valid, skid_data.
- Events:
  - push = InValid && InReady.
  - pop = OutValid && OutReady.
- States are encoded by {skid_valid, main_valid}: EMPTY (00), ONE (01), FULL (11). The state 10 is illegal and must be unreachable.
- EMPTY:
  - push: main <= InData, go to ONE.
  - otherwise: stay in EMPTY.
- ONE:
  - push && pop: main <= InData, stay in ONE.
  - push && !pop: skid <= InData, go to FULL.
  - !push && pop: main_data <= BUBBLE, go to EMPTY.
  - neither: hold.
- FULL (InReady=0, so push is impossible):
  - pop: main <= skid_data, skid_data <= BUBBLE, go to ONE.
  - otherwise: hold.
- Ordering is strict FIFO; no payload is duplicated or dropped except by Flush or Reset.
- Flush:
  - Next state is EMPTY; main_data and skid_data <= BUBBLE.
  - A push in the Flush cycle is discarded.
  - A pop in the Flush cycle completes; downstream already sampled it.
  - StallCnt is unaffected.
- Reset: all state goes to EMPTY, both data registers <= BUBBLE, StallCnt <= 0.
- StallCnt increments by 1 in each cycle where OutValid && !OutReady. It saturates at 2^CNT_W-1 and is cleared only by Reset.
- InValid while InReady=0 is legal: the payload is not taken and upstream must hold it.
- Data registers do not toggle when there is no push, pop, Flush or Reset.

## Timing
- Latency: a payload pushed in cycle N appears on OutData/OutValid in cycle N+1 when the block was EMPTY, or when it was ONE with a simultaneous pop.
- Throughput: 1 payload/cycle sustained while OutReady=1.
- InReady falls the cycle after a push-without-pop in ONE, and rises the cycle after the pop in FULL. No combinational path exists from OutReady to InReady.
- Combinational paths: OutData, OutValid, InReady, Occupancy and StallCnt are all register outputs. No path exists from any input to any output.
- Reset values: OutValid=0, InReady=1, OutData=BUBBLE, Occupancy=0, StallCnt=0.
- Priority: Reset > Flush > handshake.

## Test plan
- Reset: hold Reset for 2 cycles with InValid=1 and InData=32'hDEAD_BEEF -> OutValid=0, OutData=0, InReady=1, StallCnt=0; nothing is accepted.
- Streaming: OutReady=1, push payloads 1..8 on consecutive cycles -> OutData equals 1..8 in cycles 1..8 after the first push; InReady is always 1; StallCnt=0.
- Backpressure: push A=0x11 and B=0x22 with OutReady=0 -> Occupancy=2, InReady=0, C=0x33 is held upstream. Then raise OutReady -> output order is 0x11, 0x22, 0x33; StallCnt equals the number of stalled cycles.
- Flush in FULL with a simultaneous InValid=1 -> next cycle OutValid=0, OutData=0, Occupancy=0, InReady=1; the flushed and offered payloads never appear.
- Drain: push 0x55, pop it, then no push -> OutValid=0 and OutData=BUBBLE (test also with BUBBLE=32'hFFFF_FFFF).
- Saturation: CNT_W=4, hold OutValid=1 and OutReady=0 for 20 cycles -> StallCnt stops at 15. Flush leaves it at 15; Reset returns it to 0.
